// File: rtl/regfile_write_sched_pkg.sv
// Shared types for the register-file write scheduler: FSM states, requester IDs, default widths.
// The hazard/forwarding unit reuses the requester IDs.
package regfile_write_sched_pkg;

  localparam int unsigned WL_DATA = 32;
  localparam int unsigned WL_ADDR = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Requester that should win the next contention, given the last winner.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_write_sched_if.sv
// Writeback requester handshakes, clear control and register-file write port of the scheduler.
interface regfile_write_sched_if #(
  parameter int unsigned WL_data = regfile_write_sched_pkg::WL_DATA,
  parameter int unsigned WL_addr = regfile_write_sched_pkg::WL_ADDR
);

  logic               a_valid;
  logic [WL_addr-1:0] a_addr;
  logic [WL_data-1:0] a_data;
  logic               a_ready;

  logic               b_valid;
  logic [WL_addr-1:0] b_addr;
  logic [WL_data-1:0] b_data;
  logic               b_ready;

  logic               clr_req;
  logic               clr_busy;

  logic               rf_wr_en;
  logic [WL_addr-1:0] rf_wr_addr;
  logic [WL_data-1:0] rf_wr_data;

  // Requesters and clear source side
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
    input  a_ready, b_ready, clr_busy, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  // Scheduler side
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
    output a_ready, b_ready, clr_busy, rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arb2
  import regfile_write_sched_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic [1:0] gnt
);

  // gnt[0] = A, gnt[1] = B; a lone request is granted directly
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (other_req(last) == REQ_A) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Shares the register file write port between writeback requesters A and B and runs the
// full-register-file clear sequence through the same port.
module regfile_write_sched
  import regfile_write_sched_pkg::*;
#(
  parameter int unsigned WL_data = WL_DATA,
  parameter int unsigned WL_addr = WL_ADDR
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  regfile_write_sched_if.slave  bus
);

  state_e             state_q,      state_d;
  logic [WL_addr-1:0] clr_cnt_q,    clr_cnt_d;
  req_id_e            last_grant_q, last_grant_d;
  logic               rf_wr_en_q,   rf_wr_en_d;
  logic [WL_addr-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [WL_data-1:0] rf_wr_data_q, rf_wr_data_d;

  logic [1:0]         gnt;
  logic               a_ready_c;
  logic               b_ready_c;

  rr_arb2 u_arb (
    .req  ({bus.b_valid, bus.a_valid}),
    .last (last_grant_q),
    .gnt  (gnt)
  );

  // Next-state, handshake and write-port logic
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    a_ready_c    = 1'b0;
    b_ready_c    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else begin
          a_ready_c = gnt[0] & RST_N;
          b_ready_c = gnt[1] & RST_N;
          // $0 is hardwired: accept the transfer but never drive the write
          if (a_ready_c) begin
            last_grant_d = REQ_A;
            if (bus.a_addr != '0) begin
              rf_wr_en_d   = 1'b1;
              rf_wr_addr_d = bus.a_addr;
              rf_wr_data_d = bus.a_data;
            end
          end else if (b_ready_c) begin
            last_grant_d = REQ_B;
            if (bus.b_addr != '0) begin
              rf_wr_en_d   = 1'b1;
              rf_wr_addr_d = bus.b_addr;
              rf_wr_data_d = bus.b_data;
            end
          end
        end
      end

      ST_CLEAR: begin
        rf_wr_en_d   = 1'b1;
        rf_wr_addr_d = clr_cnt_q;
        rf_wr_data_d = '0;
        clr_cnt_d    = clr_cnt_q + WL_addr'(1);
        if (clr_cnt_q == {WL_addr{1'b1}}) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_RUN;
      clr_cnt_q    <= '0;
      last_grant_q <= REQ_B;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign bus.a_ready    = a_ready_c;
  assign bus.b_ready    = b_ready_c;
  assign bus.clr_busy   = (state_q == ST_CLEAR);
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_wr_addr = rf_wr_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: directed table, clear/abort sequences, random traffic vs model.
module tb_regfile_write_sched;

  localparam int unsigned WD   = 32;
  localparam int unsigned WA   = 5;
  localparam int unsigned NREG = 32;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  regfile_write_sched_if #(.WL_data(WD), .WL_addr(WA)) bus ();

  regfile_write_sched #(.WL_data(WD), .WL_addr(WA)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic          av;
    logic [WA-1:0] aa;
    logic [WD-1:0] ad;
    logic          bv;
    logic [WA-1:0] ba;
    logic [WD-1:0] bd;
    logic          ear;
    logic          ebr;
    logic          een;
    logic [WA-1:0] eaddr;
    logic [WD-1:0] edata;
  } vec_t;

  vec_t tab [9];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining clear writes, who won last, and the expected write-port view
  bit            m_last_a;
  int            m_clr_left;
  int            m_clr_addr;
  bit            m_en;
  logic [WA-1:0] m_addr;
  logic [WD-1:0] m_data;
  bit            m_ar, m_br;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_last_a   = 1'b0;
    m_clr_left = 0;
    m_clr_addr = 0;
    m_en       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
  endfunction

  function automatic void model_eval();
    m_ar = 1'b0;
    m_br = 1'b0;
    if (m_clr_left == 0 && !bus.clr_req) begin
      if (bus.a_valid && bus.b_valid) begin
        m_ar = !m_last_a;
        m_br = m_last_a;
      end else begin
        m_ar = bus.a_valid;
        m_br = bus.b_valid;
      end
    end
  endfunction

  task automatic model_check();
    chk("a_ready", 64'(bus.a_ready), 64'(m_ar));
    chk("b_ready", 64'(bus.b_ready), 64'(m_br));
    chk("clr_busy", 64'(bus.clr_busy), 64'(m_clr_left > 0));
    chk("rf_wr_en", 64'(bus.rf_wr_en), 64'(m_en));
    chk("rf_wr_addr", 64'(bus.rf_wr_addr), 64'(m_addr));
    chk("rf_wr_data", 64'(bus.rf_wr_data), 64'(m_data));
  endtask

  function automatic void model_advance();
    if (m_clr_left > 0) begin
      m_en = 1'b1;
      m_addr = WA'(m_clr_addr);
      m_data = '0;
      m_clr_addr++;
      m_clr_left--;
    end else if (bus.clr_req) begin
      m_clr_left = NREG;
      m_clr_addr = 0;
      m_en = 1'b0;
    end else if (m_ar) begin
      m_last_a = 1'b1;
      m_en = (bus.a_addr != 0);
      if (m_en) begin
        m_addr = bus.a_addr;
        m_data = bus.a_data;
      end
    end else if (m_br) begin
      m_last_a = 1'b0;
      m_en = (bus.b_addr != 0);
      if (m_en) begin
        m_addr = bus.b_addr;
        m_data = bus.b_data;
      end
    end else begin
      m_en = 1'b0;
    end
  endfunction

  // Apply one cycle of inputs after the falling edge and evaluate the model's handshake view
  task automatic drive(input logic av, input logic [WA-1:0] aa, input logic [WD-1:0] ad,
                       input logic bv, input logic [WA-1:0] ba, input logic [WD-1:0] bd,
                       input logic clr);
    @(negedge CLK);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.clr_req = clr;
    #1;
    model_eval();
  endtask

  task automatic step(input logic av, input logic [WA-1:0] aa, input logic [WD-1:0] ad,
                      input logic bv, input logic [WA-1:0] ba, input logic [WD-1:0] bd,
                      input logic clr);
    drive(av, aa, ad, bv, ba, bd, clr);
    model_check();
    model_advance();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_en"},   64'(bus.rf_wr_en),   64'd0);
    chk({tag, "_addr"}, 64'(bus.rf_wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(bus.rf_wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(bus.clr_busy),   64'd0);
    chk({tag, "_ar"},   64'(bus.a_ready),    64'd0);
    chk({tag, "_br"},   64'(bus.b_ready),    64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          ra_v, rb_v;
    logic [WA-1:0] ra_a, rb_a;
    logic [WD-1:0] ra_d, rb_d;

    // contention A,B,A,B then A alone, then B to $0
    tab[0] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tab[1] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11};
    tab[2] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22};
    tab[3] = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33};
    tab[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd4, 32'h44};
    tab[5] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h44};
    tab[6] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h7,  1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    tab[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tab[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};

    RST_N = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h3;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h4;
    bus.clr_req = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk_zero_outputs("reset");
    @(negedge CLK);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    RST_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tab[i].av, tab[i].aa, tab[i].ad, tab[i].bv, tab[i].ba, tab[i].bd, 1'b0);
      chk($sformatf("tab%0d_ar", i), 64'(bus.a_ready), 64'(tab[i].ear));
      chk($sformatf("tab%0d_br", i), 64'(bus.b_ready), 64'(tab[i].ebr));
      chk($sformatf("tab%0d_en", i), 64'(bus.rf_wr_en), 64'(tab[i].een));
      chk($sformatf("tab%0d_addr", i), 64'(bus.rf_wr_addr), 64'(tab[i].eaddr));
      chk($sformatf("tab%0d_data", i), 64'(bus.rf_wr_data), 64'(tab[i].edata));
      model_check();
      model_advance();
    end

    // Clear with A pending in the same cycle; a second clr_req mid-sequence is ignored
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, (k == 5));
      chk($sformatf("clr%0d_busy", k), 64'(bus.clr_busy), 64'(k <= 32));
      if (k >= 2 && k <= 33) begin
        chk($sformatf("clr%0d_en", k), 64'(bus.rf_wr_en), 64'd1);
        chk($sformatf("clr%0d_addr", k), 64'(bus.rf_wr_addr), 64'(k - 2));
        chk($sformatf("clr%0d_data", k), 64'(bus.rf_wr_data), 64'd0);
      end
      if (k == 33) chk("clr_a_after", 64'(bus.a_ready), 64'd1);
      if (k == 34) chk("clr_a_write", 64'(bus.rf_wr_addr), 64'd9);
      model_check();
      model_advance();
    end

    // Reset in the middle of a clear (clr_cnt = 10), then restart from address 0
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      step(1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0);
    end
    #1;
    RST_N = 1'b0;
    #1;
    chk_zero_outputs("abort");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.a_valid = 1'b0;
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("restart_en", 64'(bus.rf_wr_en), 64'd1);
    chk("restart_addr", 64'(bus.rf_wr_addr), 64'd0);
    model_check();
    model_advance();

    // Random traffic: requesters hold until accepted, occasional clear pulses
    ra_v = 1'b0; ra_a = '0; ra_d = '0;
    rb_v = 1'b0; rb_a = '0; rb_d = '0;
    for (int n = 0; n < 1500; n++) begin
      step(ra_v, ra_a, ra_d, rb_v, rb_a, rb_d, ($urandom_range(0, 63) == 0));
      if (m_ar) ra_v = 1'b0;
      if (m_br) rb_v = 1'b0;
      if (!ra_v && $urandom_range(0, 1) == 1) begin
        ra_v = 1'b1; ra_a = WA'($urandom_range(0, NREG - 1)); ra_d = WD'($urandom);
      end
      if (!rb_v && $urandom_range(0, 1) == 1) begin
        rb_v = 1'b1; rb_a = WA'($urandom_range(0, NREG - 1)); rb_d = WD'($urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
